pipeline_hazard_unit: RTL
=========================

# pipeline_hazard_unit

Parametrised hazard and forwarding controller for the five-stage RISC-V pipeline. Combines per-operand bypass selection for the E stage, load-use stall and bubble insertion, and a single-entry scoreboard for the multi-cycle multiply/divide unit (MDU), including its structural, RAW and WAW interlocks. Control-flow flushes from the E stage also pass through this block. It sits beside the pipeline registers and drives their stall and flush enables.

## Interface
- NUM_SRC, 2: source operands per instruction (1..3).
- REG_ADDR_W, 5: register address width.
- MDU_LATENCY, 4: cycles the MDU is busy per operation (≥2).
- i_clk  in  1  clock, all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rs_addr_D  in  NUM_SRC*REG_ADDR_W  D-stage source addresses. Operand k is at bits [k*REG_ADDR_W +: REG_ADDR_W].
- i_rs_used_D  in  NUM_SRC  D-stage operand k is actually read.
- i_rd_addr_D, i_rd_wren_D  in  REG_ADDR_W, 1  D-stage destination address and write enable.
- i_mdu_op_D  in  1  the D-stage instruction is an MDU operation.
- i_rs_addr_E  in  NUM_SRC*REG_ADDR_W  E-stage source addresses, same packing as i_rs_addr_D.
- i_rd_addr_E  in  REG_ADDR_W  E-stage destination address.
- i_mem_rden_E  in  1  the E-stage instruction is a load.
- i_mdu_start_E  in  1  the E-stage instruction launches an MDU operation.
- i_rd_addr_M, i_rd_wren_M  in  REG_ADDR_W, 1  M-stage destination address and write enable.
- i_rd_addr_W, i_rd_wren_W  in  REG_ADDR_W, 1  W-stage destination address and write enable.
- i_redirect_E  in  1  branch or jump mispredict resolved in E.
- o_forward  out  2*NUM_SRC  per-operand bypass select, operand k at bits [2k+1:2k]: 00 register file, 10 M stage, 01 W stage.
- o_stall_F, o_stall_D  out  1  hold the PC and the IF/ID register.
- o_flush_D, o_flush_E  out  1  convert the IF/ID or ID/EX contents into a bubble.
- o_mdu_busy  out  1  MDU operation in flight.
- o_mdu_done  out  1  one-cycle pulse; the MDU result is written back in this cycle.
- o_mdu_rd  out  REG_ADDR_W  destination register of the in-flight MDU operation.

## Operation
- **Forwarding (combinational)**, evaluated for each operand k:
  - Select M (10) if i_rd_wren_M, rd_M≠0 and rd_M==rs_E[k].
  - Otherwise select W (01) on the same test against rd_W.
  - Otherwise 00.
  - M has priority over W. Register x0 is never forwarded.
- **Load-use**: hazard when i_mem_rden_E, rd_E≠0 and rd_E equals any rs_D[k] whose i_rs_used_D[k]=1. Response: assert o_stall_F, o_stall_D and o_flush_E for exactly one cycle.
- **MDU scoreboard** state:
  - cnt: width clog2(MDU_LATENCY+1).
  - pend_rd: REG_ADDR_W bits.
  - pend_v: 1 bit, set when pend_rd≠0.
- **Launch**: when i_mdu_start_E and cnt==0:
  - cnt←MDU_LATENCY.
  - pend_rd←rd_E.
  - pend_v←(rd_E≠0).
- **Countdown**: cnt decrements every cycle while nonzero.
  - o_mdu_busy = (cnt≠0).
  - o_mdu_done = (cnt==1).
  - pend_v clears on the edge where cnt goes from 1 to 0.
  - o_mdu_rd = pend_rd.
- **Launch while busy**: i_mdu_start_E with cnt≠0 is a protocol violation and is ignored. The scoreboard is unchanged.
- **MDU interlock**: stall F and D, and flush E, when any of the following holds:
  - Structural: i_mdu_op_D and (o_mdu_busy, or i_mdu_start_E).
  - RAW: any used rs_D[k] matches a pending destination. Pending means pend_v with pend_rd, or i_mdu_start_E with rd_E≠0.
  - WAW: i_rd_wren_D and rd_D matches a pending destination as defined for RAW.
- **Redirect**:
  - i_redirect_E asserts o_flush_D and o_flush_E.
  - It forces o_stall_F and o_stall_D to 0, so the redirect always wins over every stall source.
  - It does not abort an MDU operation already launched.
- **Stall sources**: load-use and MDU interlock may coincide. The outputs are their OR; there is no double counting.
- **Register file**: write-first. A stalled instruction that is released after o_mdu_done reads the new value directly.

## Timing
- Reset values: cnt=0, pend_v=0, pend_rd=0. All outputs are 0 in the cycle after i_reset is sampled high and for as long as it stays high.
- **Reset mid-operation**: tracking is aborted, busy drops, and no done pulse is produced.
- **Latency**: forwarding, stall and flush are combinational, with zero-cycle latency from their inputs.
- **MDU cycle sequence**, for a launch sampled at edge t:
  - o_mdu_busy is high in cycles t+1 .. t+MDU_LATENCY.
  - o_mdu_done is high in cycle t+MDU_LATENCY only.
  - A dependent instruction in D is stalled from cycle t through t+MDU_LATENCY.
  - That instruction advances at the edge ending cycle t+MDU_LATENCY.
- **Back-to-back MDU ops**: a second MDU instruction can be launched no earlier than cycle t+MDU_LATENCY+1.
- **Bounds**: cnt never exceeds MDU_LATENCY and never underflows below 0.

## Test plan
- **Forward priority**: rd_M=rd_W=5 with both write enables set, rs_E[0]=5, rs_E[1]=0 → o_forward[1:0]=10, o_forward[3:2]=00. Repeat with i_rd_wren_M=0 → o_forward[1:0]=01.
- **Load-use**: load rd_E=7 in E, D reads x7 on operand 1 with i_rs_used_D[1]=1 → exactly one cycle of stall_F, stall_D and flush_E. With i_rs_used_D[1]=0 → no stall.
- **MDU RAW**: start with rd_E=9 and MDU_LATENCY=4, D reads x9 → stall in cycles t..t+4, done pulse at t+4, busy low at t+5, o_mdu_rd=9 during busy.
- **MDU to x0**: start with rd_E=0, D reads x0 → no RAW stall. busy is still high for 4 cycles, and a second MDU op in D is stalled structurally.
- **Redirect vs stall**: load-use hazard together with i_redirect_E=1 → stall_F=stall_D=0 and flush_D=flush_E=1. An MDU op launched earlier still produces its done pulse on schedule.
- **Reset mid-op**: i_reset raised at cnt=2 → next cycle busy=0, done never pulses, and a dependent instruction in D is released.

Source files
------------

// File: rtl/pipeline_hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle: per-stage register addresses and enables in, stall/flush/bypass controls out.
// The master side is the pipeline datapath; the slave side is the hazard unit.
interface pipeline_hazard_unit_if #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5
);
    logic [NUM_SRC*REG_ADDR_W-1:0] i_rs_addr_D;
    logic [NUM_SRC-1:0]            i_rs_used_D;
    logic [REG_ADDR_W-1:0]         i_rd_addr_D;
    logic                          i_rd_wren_D;
    logic                          i_mdu_op_D;
    logic [NUM_SRC*REG_ADDR_W-1:0] i_rs_addr_E;
    logic [REG_ADDR_W-1:0]         i_rd_addr_E;
    logic                          i_mem_rden_E;
    logic                          i_mdu_start_E;
    logic [REG_ADDR_W-1:0]         i_rd_addr_M;
    logic                          i_rd_wren_M;
    logic [REG_ADDR_W-1:0]         i_rd_addr_W;
    logic                          i_rd_wren_W;
    logic                          i_redirect_E;
    logic [2*NUM_SRC-1:0]          o_forward;
    logic                          o_stall_F;
    logic                          o_stall_D;
    logic                          o_flush_D;
    logic                          o_flush_E;
    logic                          o_mdu_busy;
    logic                          o_mdu_done;
    logic [REG_ADDR_W-1:0]         o_mdu_rd;

    modport master (
        output i_rs_addr_D, i_rs_used_D, i_rd_addr_D, i_rd_wren_D, i_mdu_op_D,
               i_rs_addr_E, i_rd_addr_E, i_mem_rden_E, i_mdu_start_E,
               i_rd_addr_M, i_rd_wren_M, i_rd_addr_W, i_rd_wren_W, i_redirect_E,
        input  o_forward, o_stall_F, o_stall_D, o_flush_D, o_flush_E,
               o_mdu_busy, o_mdu_done, o_mdu_rd
    );

    modport slave (
        input  i_rs_addr_D, i_rs_used_D, i_rd_addr_D, i_rd_wren_D, i_mdu_op_D,
               i_rs_addr_E, i_rd_addr_E, i_mem_rden_E, i_mdu_start_E,
               i_rd_addr_M, i_rd_wren_M, i_rd_addr_W, i_rd_wren_W, i_redirect_E,
        output o_forward, o_stall_F, o_stall_D, o_flush_D, o_flush_E,
               o_mdu_busy, o_mdu_done, o_mdu_rd
    );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Bypass select, load-use and MDU scoreboard interlocks, redirect flushes; all controls combinational (zero latency).
// Never backpressured itself: it drives the pipeline stall/flush enables, and a redirect overrides every stall.
module pipeline_hazard_unit #(
    parameter int NUM_SRC     = 2,
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    pipeline_hazard_unit_if.slave  hif
);
    localparam int               CNT_W    = $clog2(MDU_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]      cnt;
    logic [REG_ADDR_W-1:0] pend_rd;
    logic                  pend_v;
    logic                  rst_q;

    always_ff @(posedge i_clk) begin
        rst_q <= i_reset;
        if (i_reset) begin
            cnt     <= '0;
            pend_rd <= '0;
            pend_v  <= 1'b0;
        end else if (cnt == '0) begin
            if (hif.i_mdu_start_E) begin
                cnt     <= CNT_LOAD;
                pend_rd <= hif.i_rd_addr_E;
                pend_v  <= (hif.i_rd_addr_E != '0);
            end
        end else begin
            // A start while busy is a protocol violation and is simply dropped.
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                pend_v <= 1'b0;
            end
        end
    end

    logic                  out_gate;
    logic                  busy;
    logic                  load_pend;
    logic                  start_pend;
    logic                  load_use;
    logic                  raw;
    logic                  waw;
    logic                  structural;
    logic                  stall_any;
    logic [2*NUM_SRC-1:0]  fwd;
    logic [REG_ADDR_W-1:0] rs_d;
    logic [REG_ADDR_W-1:0] rs_e;

    assign busy       = (cnt != '0);
    assign load_pend  = hif.i_mem_rden_E  && (hif.i_rd_addr_E != '0);
    assign start_pend = hif.i_mdu_start_E && (hif.i_rd_addr_E != '0);

    always_comb begin
        fwd      = '0;
        load_use = 1'b0;
        raw      = 1'b0;
        rs_d     = '0;
        rs_e     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rs_e = hif.i_rs_addr_E[k*REG_ADDR_W +: REG_ADDR_W];
            rs_d = hif.i_rs_addr_D[k*REG_ADDR_W +: REG_ADDR_W];
            if (hif.i_rd_wren_M && (hif.i_rd_addr_M != '0) && (hif.i_rd_addr_M == rs_e)) begin
                fwd[2*k +: 2] = 2'b10;
            end else if (hif.i_rd_wren_W && (hif.i_rd_addr_W != '0) && (hif.i_rd_addr_W == rs_e)) begin
                fwd[2*k +: 2] = 2'b01;
            end
            if (hif.i_rs_used_D[k]) begin
                if (load_pend && (rs_d == hif.i_rd_addr_E)) begin
                    load_use = 1'b1;
                end
                // Pending MDU destinations: the tracked one plus the one launching this cycle.
                if ((pend_v && (rs_d == pend_rd)) || (start_pend && (rs_d == hif.i_rd_addr_E))) begin
                    raw = 1'b1;
                end
            end
        end
    end

    assign waw = hif.i_rd_wren_D &&
                 ((pend_v && (hif.i_rd_addr_D == pend_rd)) ||
                  (start_pend && (hif.i_rd_addr_D == hif.i_rd_addr_E)));
    assign structural = hif.i_mdu_op_D && (busy || hif.i_mdu_start_E);
    assign stall_any  = load_use || raw || waw || structural;

    // Outputs read as zero while reset is asserted and in the cycle after its last sample.
    assign out_gate = i_reset || rst_q;

    assign hif.o_forward  = out_gate ? '0 : fwd;
    assign hif.o_stall_F  = !out_gate && stall_any && !hif.i_redirect_E;
    assign hif.o_stall_D  = !out_gate && stall_any && !hif.i_redirect_E;
    assign hif.o_flush_D  = !out_gate && hif.i_redirect_E;
    assign hif.o_flush_E  = !out_gate && (stall_any || hif.i_redirect_E);
    assign hif.o_mdu_busy = !out_gate && busy;
    assign hif.o_mdu_done = !out_gate && (cnt == CNT_ONE);
    assign hif.o_mdu_rd   = out_gate ? '0 : pend_rd;
endmodule
